// File: rtl/mpi_bus_arbiter.sv
// Round-robin master for the MPI bus: IDLE -> SETUP -> ACCESS -> DONE, all outputs registered.
// Define MPI_ARB_TIMEOUT_EN to bound ACCESS to TIMEOUT cycles and report rsp_err on expiry.
module mpi_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk_100m,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*16-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    cpu_cs_n,
  output logic                    cpu_rd_n,
  output logic                    cpu_we_n,
  output logic [15:0]             cpu_addr,
  output logic [31:0]             cpu_data_o,
  output logic                    cpu_data_oe,
  input  logic [31:0]             cpu_data_i,
  input  logic                    cpu_rdy_n
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t               state_reg, state_next;
  logic [GW-1:0]        last_grant_reg, last_grant_next;
  logic [GW-1:0]        grant_reg, grant_next;
  logic                 we_reg, we_next;
  logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
  logic [NUM_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
  logic [31:0]          rsp_rdata_reg, rsp_rdata_next;
  logic                 cs_n_reg, cs_n_next;
  logic                 rd_n_reg, rd_n_next;
  logic                 we_n_reg, we_n_next;
  logic [15:0]          addr_reg, addr_next;
  logic [31:0]          data_o_reg, data_o_next;
  logic                 oe_reg, oe_next;
  logic                 finish;

  logic [15:0]          addr_arr  [NUM_REQ];
  logic [31:0]          wdata_arr [NUM_REQ];
  logic                 found;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;
  int                   idx;

`ifdef MPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 err_reg, err_next;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[16*gi +: 16];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
    end
  endgenerate

  // First valid requester after last_grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant_reg) + k) % NUM_REQ;
      cand = idx[GW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    we_next         = we_reg;
    req_ready_next  = '0;
    rsp_valid_next  = '0;
    rsp_rdata_next  = rsp_rdata_reg;
    cs_n_next       = cs_n_reg;
    rd_n_next       = rd_n_reg;
    we_n_next       = we_n_reg;
    addr_next       = addr_reg;
    data_o_next     = data_o_reg;
    oe_next         = oe_reg;
    finish          = 1'b0;
`ifdef MPI_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    err_next        = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next           = SETUP;
          grant_next           = pick;
          last_grant_next      = pick;
          we_next              = req_we[pick];
          addr_next            = addr_arr[pick];
          data_o_next          = req_we[pick] ? wdata_arr[pick] : 32'h0;
          oe_next              = req_we[pick];
          cs_n_next            = 1'b0;
          req_ready_next[pick] = 1'b1;
        end
      end
      SETUP: begin
        state_next = ACCESS;
        rd_n_next  = we_reg;
        we_n_next  = ~we_reg;
`ifdef MPI_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      ACCESS: begin
`ifdef MPI_ARB_TIMEOUT_EN
        cnt_next = cnt_reg + CW'(1);
`endif
        // A ready slave wins even in the last allowed cycle.
        if (!cpu_rdy_n) begin
          finish         = 1'b1;
          rsp_rdata_next = we_reg ? 32'h0 : cpu_data_i;
`ifdef MPI_ARB_TIMEOUT_EN
          err_next       = 1'b0;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          finish         = 1'b1;
          rsp_rdata_next = 32'h0;
          err_next       = 1'b1;
`endif
        end
        if (finish) begin
          state_next                = DONE;
          cs_n_next                 = 1'b1;
          rd_n_next                 = 1'b1;
          we_n_next                 = 1'b1;
          oe_next                   = 1'b0;
          rsp_valid_next[grant_reg] = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GW'(NUM_REQ - 1);
      grant_reg      <= '0;
      we_reg         <= 1'b0;
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_rdata_reg  <= 32'h0;
      cs_n_reg       <= 1'b1;
      rd_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      addr_reg       <= 16'h0;
      data_o_reg     <= 32'h0;
      oe_reg         <= 1'b0;
`ifdef MPI_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      we_reg         <= we_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      cs_n_reg       <= cs_n_next;
      rd_n_reg       <= rd_n_next;
      we_n_reg       <= we_n_next;
      addr_reg       <= addr_next;
      data_o_reg     <= data_o_next;
      oe_reg         <= oe_next;
`ifdef MPI_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
`endif
    end
  end

  assign req_ready   = req_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign cpu_cs_n    = cs_n_reg;
  assign cpu_rd_n    = rd_n_reg;
  assign cpu_we_n    = we_n_reg;
  assign cpu_addr    = addr_reg;
  assign cpu_data_o  = data_o_reg;
  assign cpu_data_oe = oe_reg;
`ifdef MPI_ARB_TIMEOUT_EN
  assign rsp_err     = err_reg;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule
